// File: rtl/hangman_main.sv
//------------------------------------------------------------------------------
// hangman_main : two-pad hangman game controller with debounced pads,
//                game FSM, ASCII display rows and status LEDs.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hangman_main #(
  parameter int DEBOUNCE = 1000,
  parameter int MAX_MISS = 6
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         role_switch,
  input  logic [3:0]   input_row_host,
  input  logic [3:0]   input_row_player,
  output logic         red,
  output logic         green,
  output logic         blue,
  output logic         error,
  output logic         msg_sent,
  output logic [127:0] host_row1,
  output logic [127:0] host_row2,
  output logic [127:0] play_row1,
  output logic [127:0] play_row2
);

  localparam int         CW     = $clog2(DEBOUNCE + 1);
  localparam logic [1:0] S_SET  = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_WIN  = 2'd2;
  localparam logic [1:0] S_LOSE = 2'd3;
  localparam logic [7:0] SP     = 8'h20;

  // ---------------- pad debouncers (index 0 = host role, 1 = player role)
  logic [3:0]    raw   [2];
  logic [3:0]    in_q  [2];
  logic [3:0]    cand  [2];
  logic [CW-1:0] cnt   [2];
  logic [1:0]    armed;
  logic [1:0]    ev;
  logic [1:0]    onehot;
  logic          role_q;
  logic          role_chg;

  assign raw[0]   = role_switch ? input_row_player : input_row_host;
  assign raw[1]   = role_switch ? input_row_host   : input_row_player;
  assign role_chg = (role_switch != role_q);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      onehot[i] = (cand[i] != 4'd0) && ((cand[i] & (cand[i] - 4'd1)) == 4'd0);
      ev[i]     = armed[i] && onehot[i] && (in_q[i] == cand[i]) &&
                  (cnt[i] == CW'(DEBOUNCE - 1));
    end
  end

  always_ff @(posedge clk) begin
    role_q <= nRst ? 1'b0 : role_switch;
    for (int i = 0; i < 2; i++) begin
      if (nRst || role_chg) begin
        in_q[i]  <= 4'd0;
        cand[i]  <= 4'd0;
        cnt[i]   <= '0;
        armed[i] <= 1'b1;
      end else begin
        in_q[i] <= raw[i];
        if (in_q[i] != cand[i]) begin
          cand[i] <= in_q[i];
          cnt[i]  <= '0;
        end else if (!onehot[i] && cand[i] != 4'd0) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CW'(DEBOUNCE - 1)) begin
          cnt[i] <= cnt[i] + CW'(1);
        end else if (cand[i] == 4'd0) begin
          armed[i] <= 1'b1;
        end else if (ev[i]) begin
          armed[i] <= 1'b0;
        end
      end
    end
  end

  logic h_up, h_down, h_back, h_enter, p_up, p_down, p_enter;
  assign h_up    = ev[0] & cand[0][3];
  assign h_down  = ev[0] & cand[0][2];
  assign h_back  = ev[0] & cand[0][1];
  assign h_enter = ev[0] & cand[0][0];
  assign p_up    = ev[1] & cand[1][3];
  assign p_down  = ev[1] & cand[1][2];
  assign p_enter = ev[1] & cand[1][0];

  // ---------------- game state
  logic [1:0]  state, next_state;
  logic [4:0]  word [5];
  logic [2:0]  idx;
  logic [4:0]  sel_h, sel_p;
  logic [3:0]  miss, miss_next;
  logic [25:0] mask;
  logic [4:0]  revealed, match, rev_next;

  function automatic logic [4:0] inc(input logic [4:0] l);
    return (l == 5'd25) ? 5'd0 : l + 5'd1;
  endfunction

  function automatic logic [4:0] dec(input logic [4:0] l);
    return (l == 5'd0) ? 5'd25 : l - 5'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < 5; i++) match[i] = (word[i] == sel_p);
    rev_next  = revealed | match;
    miss_next = miss + {3'b000, ~|match};
  end

  always_ff @(posedge clk) begin
    if (nRst) state <= S_SET;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_SET:  if (h_enter && idx == 3'd4) next_state = S_PLAY;
      S_PLAY: if (p_enter && !mask[sel_p]) begin
                if (&rev_next)                        next_state = S_WIN;
                else if (miss_next == 4'(MAX_MISS))   next_state = S_LOSE;
              end
      default: if (h_enter) next_state = S_SET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      for (int i = 0; i < 5; i++) word[i] <= 5'd0;
      idx      <= 3'd0;
      sel_h    <= 5'd0;
      sel_p    <= 5'd0;
      miss     <= 4'd0;
      mask     <= 26'd0;
      revealed <= 5'd0;
      error    <= 1'b0;
      msg_sent <= 1'b0;
    end else begin
      error    <= 1'b0;
      msg_sent <= 1'b0;
      case (state)
        S_SET: begin
          if (h_up)   sel_h <= inc(sel_h);
          if (h_down) sel_h <= dec(sel_h);
          if (h_back && idx != 3'd0) idx <= idx - 3'd1;
          if (h_enter) begin
            for (int i = 0; i < 5; i++)
              if (idx == 3'(i)) word[i] <= sel_h;
            idx <= idx + 3'd1;
            if (idx == 3'd4) begin
              msg_sent <= 1'b1;
              miss     <= 4'd0;
              mask     <= 26'd0;
              revealed <= 5'd0;
              sel_p    <= 5'd0;
            end
          end
        end
        S_PLAY: begin
          if (p_up)   sel_p <= inc(sel_p);
          if (p_down) sel_p <= dec(sel_p);
          if (p_enter) begin
            if (mask[sel_p]) begin
              error <= 1'b1;
            end else begin
              mask[sel_p] <= 1'b1;
              revealed    <= rev_next;
              miss        <= miss_next;
            end
          end
        end
        default: begin
          if (h_enter) begin
            idx      <= 3'd0;
            miss     <= 4'd0;
            mask     <= 26'd0;
            revealed <= 5'd0;
            sel_h    <= 5'd0;
          end
        end
      endcase
    end
  end

  // ---------------- LEDs and display text
  function automatic logic [7:0] ch(input logic show, input logic [4:0] l);
    return show ? (8'h41 + {3'b000, l}) : 8'h5F;
  endfunction

  logic [7:0] digit;
  logic       all;
  assign digit = 8'h30 + {4'h0, miss};
  assign all   = (state == S_LOSE);

  always_comb begin
    red   = (state == S_LOSE);
    green = (state == S_WIN);
    blue  = (state == S_PLAY);

    host_row1 = {"WORD ", ch(idx > 3'd0, word[0]), ch(idx > 3'd1, word[1]),
                 ch(idx > 3'd2, word[2]), ch(idx > 3'd3, word[3]),
                 ch(idx > 3'd4, word[4]), {6{SP}}};
    host_row2 = {"SEL ", ch(1'b1, sel_h), "  MISS ", digit, {3{SP}}};

    if (state == S_SET)
      play_row1 = {"WAIT", {12{SP}}};
    else
      play_row1 = {"GUESS ", ch(all | revealed[0], word[0]),
                   ch(all | revealed[1], word[1]), ch(all | revealed[2], word[2]),
                   ch(all | revealed[3], word[3]), ch(all | revealed[4], word[4]),
                   {5{SP}}};

    case (state)
      S_WIN:   play_row2 = {"YOU WIN", {9{SP}}};
      S_LOSE:  play_row2 = {"YOU LOSE", {8{SP}}};
      default: play_row2 = {"SEL ", ch(1'b1, sel_p), "  MISS ", digit, {3{SP}}};
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hangman_main.sv
//------------------------------------------------------------------------------
// tb_hangman_main : directed self-checking bench for hangman_main.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hangman_main;

  localparam int DB = 8;
  localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, BK = 4'b0010, EN = 4'b0001;

  logic         clk = 1'b0;
  logic         nRst, role_switch;
  logic [3:0]   ih, ip;
  logic         red, green, blue, error, msg_sent;
  logic [127:0] host_row1, host_row2, play_row1, play_row2;

  int n_cmp = 0, n_bad = 0;
  int msg_cnt = 0, err_cnt = 0;
  int sh = 0, sp = 0;
  int wrong [6] = '{0, 2, 3, 5, 6, 7};

  hangman_main #(.DEBOUNCE(DB), .MAX_MISS(6)) dut (
    .clk(clk), .nRst(nRst), .role_switch(role_switch),
    .input_row_host(ih), .input_row_player(ip),
    .red(red), .green(green), .blue(blue), .error(error), .msg_sent(msg_sent),
    .host_row1(host_row1), .host_row2(host_row2),
    .play_row1(play_row1), .play_row2(play_row2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (msg_sent) msg_cnt++;
    if (error)    err_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // pin: 0 = input_row_host pin, 1 = input_row_player pin
  task automatic press(input bit pin, input logic [3:0] b, input int hold);
    if (pin) ip = b; else ih = b;
    repeat (hold) @(posedge clk);
    if (pin) ip = 4'd0; else ih = 4'd0;
    repeat (DB + 6) @(posedge clk);
    #1;
  endtask

  task automatic goto_letter(input bit pin, inout int cur, input int tgt);
    int steps;
    steps = (tgt - cur + 26) % 26;
    for (int k = 0; k < steps; k++) press(pin, UP, DB + 6);
    cur = tgt;
  endtask

  initial begin
    nRst = 1'b1; role_switch = 1'b0; ih = 4'd0; ip = 4'd0;
    repeat (2) @(posedge clk);
    #1 nRst = 1'b0;
    check("rst_rgb", {red, green, blue}, 3'b000);
    check("rst_err", error, 1'b0);
    check("rst_msg", msg_sent, 1'b0);
    check("rst_h1", host_row1, "WORD _____      ");
    check("rst_h2", host_row2, "SEL A  MISS 0   ");
    check("rst_p1", play_row1, "WAIT            ");
    check("rst_p2", play_row2, "SEL A  MISS 0   ");

    press(0, BK, DB + 6);
    check("back_idx0", host_row1, "WORD _____      ");
    press(1, UP, DB + 6);
    check("player_ign", play_row2, "SEL A  MISS 0   ");
    press(0, DN, DB + 6);
    check("wrap_down", host_row2, "SEL Z  MISS 0   ");
    press(0, UP, DB + 6);
    press(0, UP, DB + 6);
    check("wrap_up", host_row2, "SEL B  MISS 0   ");
    press(0, EN, DB + 6);
    repeat (12) press(0, DN, DB + 6);
    check("sel_p", host_row2, "SEL P  MISS 0   ");
    press(0, EN, DB + 6);
    press(0, EN, DB + 6);
    press(0, UP, DB + 6);
    press(0, EN, DB + 6);
    check("word4", host_row1, "WORD BPPQ_      ");
    press(0, BK, DB + 6);
    check("back", host_row1, "WORD BPP__      ");
    repeat (5) press(0, DN, DB + 6);
    press(0, EN, DB + 6);
    check("no_msg_yet", msg_cnt, 0);
    repeat (7) press(0, DN, DB + 6);
    press(0, EN, DB + 6);
    check("msg1", msg_cnt, 1);
    check("play_rgb", {red, green, blue}, 3'b001);
    check("play_p1", play_row1, "GUESS _____     ");
    check("word_done", host_row1, "WORD BPPLE      ");

    sp = 0;
    goto_letter(1, sp, 15);
    press(1, EN, DB + 6);
    check("hit_p1", play_row1, "GUESS _PP__     ");
    check("hit_p2", play_row2, "SEL P  MISS 0   ");
    press(1, EN, DB + 6);
    check("repeat_err", err_cnt, 1);
    check("repeat_miss", play_row2, "SEL P  MISS 0   ");

    for (int i = 0; i < 6; i++) begin
      goto_letter(1, sp, wrong[i]);
      press(1, EN, DB + 6);
      if (i == 4) begin
        check("miss5", play_row2, "SEL G  MISS 5   ");
        check("miss5_rgb", {red, green, blue}, 3'b001);
      end
    end
    check("lose_rgb", {red, green, blue}, 3'b100);
    check("lose_p2", play_row2, "YOU LOSE        ");
    check("lose_p1", play_row1, "GUESS BPPLE     ");
    check("lose_h2", host_row2, "SEL E  MISS 6   ");
    press(0, EN, DB + 6);
    check("restart_rgb", {red, green, blue}, 3'b000);
    check("restart_h1", host_row1, "WORD _____      ");
    check("restart_h2", host_row2, "SEL A  MISS 0   ");
    check("restart_p1", play_row1, "WAIT            ");

    sh = 0;
    goto_letter(0, sh, 1);  press(0, EN, DB + 6);
    goto_letter(0, sh, 15); press(0, EN, DB + 6); press(0, EN, DB + 6);
    goto_letter(0, sh, 11); press(0, EN, DB + 6);
    goto_letter(0, sh, 4);  press(0, EN, DB + 6);
    check("msg2", msg_cnt, 2);
    check("selp_reset", play_row2, "SEL A  MISS 0   ");

    press(1, UP, 100 * DB);
    check("long_hold", play_row2, "SEL B  MISS 0   ");
    press(1, EN, DB + 6);
    check("guess_b", play_row1, "GUESS B____     ");
    ip = UP; repeat (DB + 6) @(posedge clk);
    ip = 4'd0; repeat (3) @(posedge clk);
    ip = UP; repeat (DB + 6) @(posedge clk);
    ip = 4'd0; repeat (DB + 6) @(posedge clk);
    #1;
    check("bounce", play_row2, "SEL C  MISS 0   ");
    sp = 2;
    goto_letter(1, sp, 15); press(1, EN, DB + 6);
    goto_letter(1, sp, 11); press(1, EN, DB + 6);
    check("guess_bpl", play_row1, "GUESS BPPL_     ");
    goto_letter(1, sp, 4);  press(1, EN, DB + 6);
    check("win_rgb", {red, green, blue}, 3'b010);
    check("win_p2", play_row2, "YOU WIN         ");
    check("win_h2", host_row2, "SEL E  MISS 0   ");
    check("win_err", err_cnt, 1);
    press(0, EN, DB + 6);
    check("back_set", {red, green, blue}, 3'b000);

    role_switch = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    press(1, EN, DB / 2);
    press(0, EN, DB + 6);
    check("short_press", host_row1, "WORD _____      ");
    repeat (5) press(1, EN, DB + 6);
    check("sw_msg", msg_cnt, 3);
    check("sw_rgb", {red, green, blue}, 3'b001);
    check("sw_word", host_row1, "WORD AAAAA      ");
    press(0, EN, DB + 6);
    check("sw_win", {red, green, blue}, 3'b010);
    check("sw_p1", play_row1, "GUESS AAAAA     ");

    nRst = 1'b1;
    @(posedge clk);
    #1 nRst = 1'b0;
    check("mid_rst_rgb", {red, green, blue}, 3'b000);
    check("mid_rst_h1", host_row1, "WORD _____      ");
    check("mid_rst_p2", play_row2, "SEL A  MISS 0   ");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hangman_main.md
# hangman_main

Top-level game controller for two-station wireless hangman. It debounces two 4-button pads (host and player) and runs the game state machine. The host enters a 5-letter secret word; the player guesses letters against it. The block drives four 16-character ASCII display rows, RGB status LEDs, an error flag and a word-sent pulse toward the radio link.

## Interface
- DEBOUNCE, 1000: clock cycles a pad pattern must be stable before it is accepted, and again before release is accepted.
- MAX_MISS, 6: number of wrong guesses that loses the game (1–9).
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- nRst  in  1  reset; synchronous, active-high.
- role_switch  in  1  0: input_row_host is the host pad and input_row_player is the player pad; 1: the two pads are swapped.
- input_row_host  in  4  pad A buttons, one-hot, bit3..bit0 = UP, DOWN, BACK, ENTER.
- input_row_player  in  4  pad B buttons, same encoding.
- red, green, blue  out  1 each  status LEDs.
- error  out  1  one-cycle pulse on an illegal player action.
- msg_sent  out  1  one-cycle pulse when the secret word is committed.
- host_row1, host_row2, play_row1, play_row2  out  128 each  16 ASCII characters; character 0 is in [127:120].

## Operation
- Each pad has one input register followed by a debouncer. An event fires when a pattern with exactly one bit set has been stable for DEBOUNCE cycles. The debouncer then re-arms only after all-zero has been stable for DEBOUNCE cycles.
- Patterns with more than one bit set are ignored and reset the stability counter. A role_switch change also resets both debouncers.
- Each side has a selected letter, selH and selP, each reset to 'A'.
- UP adds 1 to the selected letter with wrap Z→A. DOWN subtracts 1 with wrap A→Z.
- States:
  - SET_WORD: host UP/DOWN change selH. Host ENTER appends selH at the next word index (0..4). Host BACK removes the last letter; BACK at index 0 is ignored. The ENTER that stores the 5th letter pulses msg_sent, clears miss, hit and guessed state, sets selP='A', and goes to PLAY. All player events are ignored.
  - PLAY: player UP/DOWN change selP. Player ENTER handling:
    - selP already in the 26-bit guessed mask: error pulse, nothing else changes.
    - Otherwise set the guessed bit. Mark every word position equal to selP as revealed.
    - If no position matched, miss+1.
    - If all 5 positions are revealed, go to WIN. Else if miss reaches MAX_MISS, go to LOSE.
    - Host events and player BACK are ignored.
  - WIN / LOSE: host ENTER clears the word, index, miss and mask, sets selH='A', and returns to SET_WORD. All other events are ignored.
- LEDs (rgb): SET_WORD 000, PLAY 001, WIN 010, LOSE 100.
- Displays (pad with spaces to 16 characters):
  - host_row1 = "WORD " followed by 5 characters: entered letters, '_' for unentered positions.
  - host_row2 = "SEL x  MISS d" with x = selH and d = miss as an ASCII digit.
  - play_row1 in SET_WORD = "WAIT". Otherwise "GUESS " followed by 5 characters: revealed letter or '_'; in LOSE all letters are shown.
  - play_row2 = "SEL x  MISS d" with x = selP in PLAY; "YOU WIN" in WIN; "YOU LOSE" in LOSE.

## Timing
- Reset values: state SET_WORD, rgb 000, error 0, msg_sent 0, selH and selP 'A', word empty, miss 0.
- Reset displays: host_row1 "WORD _____", host_row2 "SEL A  MISS 0", play_row1 "WAIT", play_row2 "SEL A  MISS 0".
- Pad to event: a stable press produces its event DEBOUNCE+1 cycles after the pattern first appears at the pin (1 register stage plus DEBOUNCE).
- All state, display and LED updates become visible on the cycle after the event. error and msg_sent are registered and high for exactly that one cycle.
- A press is held indefinitely: one event only. Press, short release (under DEBOUNCE), press again: still one event.
- Both pads firing in the same cycle: each is handled by its own rules. Only one pad is active in any state, so there is no conflict.
- nRst asserted mid-operation: everything returns to reset values on the next rising edge, including the debouncers.

## Test plan
- Reset: hold nRst for 2 cycles → rgb 000, error 0, msg_sent 0, host_row1 "WORD _____", play_row1 "WAIT".
- Word entry (role_switch=0): host UP once ('B'), ENTER; then DOWN until 'P', ENTER; continue until "BPPLE" is entered → msg_sent pulses 1 cycle, blue=1, play_row1 "GUESS _____".
- Correct guess: player selects 'P', ENTER → play_row1 "GUESS _PP__", miss 0. Repeat 'P' → error pulse, miss unchanged.
- Loss: 6 wrong guesses → red=1, play_row2 "YOU LOSE", play_row1 shows "BPPLE". Host ENTER → SET_WORD, rgb 000.
- Win and debounce: press held for 100×DEBOUNCE cycles gives a single event. Guess B, P, L, E → green=1, "YOU WIN".
- role_switch=1: input_row_player drives word entry and input_row_host guesses. Presses shorter than DEBOUNCE cycles produce no event.
